codma_read_machine: RTL and testbench
=====================================

Name: codma_read_machine

Overview:
- Bus-read engine directly downstream of the CoDMA control FSM (codma_machine).
- Accepts one read request (address + size code) and drives a single burst read on the system bus.
- Assembles returned beats into an 8x32 data register and exposes its own state, so the control FSM can sequence on the read state returning to RD_IDLE.
- One instance per CoDMA; the write machine is a sibling.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles waiting for grant or for the next beat (used only with the optional feature).
- ADDR_W, 32: bus address width.

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  reset
- need_read_i  in  1  read request level from the control FSM
- need_read_o  out  1  request-pending feedback; the control FSM re-registers it each cycle
- reg_addr  in  32  burst start address, byte address, word-aligned
- reg_size  in  8  size code: 3 = 2 words (8B), 8 = 4 words (16B), 9 = 8 words (32B)
- rd_state_r  out  read_state_t  registered state
- rd_state_next_s  out  read_state_t  combinational next state
- data_reg  out  8x32  assembled read data; word 0 = lowest address
- rd_error_o  out  1  one-cycle pulse on bus error, bad size code or timeout
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus grant
- bus_addr_o  out  32  bus address (burst start)
- bus_size_o  out  8  size code forwarded to the bus
- bus_rvalid_i  in  1  read beat valid
- bus_rdata_i  in  32  read beat data
- bus_error_i  in  1  bus error, sampled in RD_REQUEST and RD_GRANTED

Behaviour:
- Interface: single clock clk_i; reset reset_n_i is asynchronous, active-low.
- Reset values:
  - rd_state_r = RD_IDLE
  - data_reg = 0
  - bus_req_o = 0, bus_addr_o = 0, bus_size_o = 0
  - rd_error_o = 0
  - beat counter = 0
  - need_read_o = 0
- RD_IDLE:
  - need_read_o = need_read_i.
  - If need_read_i=1: latch reg_addr/reg_size into bus_addr_o/bus_size_o and set beats_total from the size code.
  - Valid size code: next = RD_REQUEST and need_read_o = 0 in that same cycle (combinational), so the control FSM drops its request next cycle.
  - Invalid size code (anything other than 3/8/9): pulse rd_error_o, stay RD_IDLE, need_read_o = 0.
- RD_REQUEST:
  - bus_req_o = 1.
  - bus_gnt_i = 1 -> RD_GRANTED; clear beat counter; zero data_reg so unfilled words read as 0.
- RD_GRANTED:
  - bus_req_o = 0.
  - Each cycle with bus_rvalid_i = 1: data_reg[cnt] <= bus_rdata_i; cnt++.
  - When the final beat arrives (cnt == beats_total-1 with rvalid): next = RD_IDLE in the same cycle, so rd_state_next_s == RD_IDLE coincides with the last beat.
  - data_reg is stable from the following cycle until the next grant.
- Latency: request seen in IDLE -> bus_req_o next cycle; last beat -> state RD_IDLE next cycle.
- bus_error_i in RD_REQUEST/RD_GRANTED: rd_error_o pulses next cycle; state -> RD_IDLE; bus_req_o drops; data_reg keeps partial data.
- Simultaneous bus_error_i and last beat: error wins; the beat is still captured.
- rvalid beyond beats_total or in RD_IDLE/RD_REQUEST: ignored.
- need_read_i change mid-burst: ignored. A new request is only accepted in RD_IDLE, and not in the same cycle the previous burst ends.
- Async reset mid-burst: immediate return to reset values; no bus_req_o glitch after deassertion.
- Beat counter is 4 bits; no wrap is possible because it is capped at beats_total (max 8).

Optional Feature:
- Macro: CODMA_RD_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in RD_REQUEST without grant, and in RD_GRANTED without rvalid.
  - It reloads on each state entry and on each beat.
  - On reaching TIMEOUT_CYCLES: rd_error_o pulses, bus_req_o drops, state -> RD_IDLE.
- Undefined:
  - No counter logic is generated; TIMEOUT_CYCLES is unused.
  - The machine waits indefinitely.

Decomposition:
- read_pkg holds:
  - read_state_t enum {RD_IDLE, RD_REQUEST, RD_GRANTED}
  - size code constants RD_SIZE_8B=3, RD_SIZE_16B=8, RD_SIZE_32B=9
  - function size_to_beats() returning 2/4/8, or 0 for an invalid code.
- The watchdog is a natural sub-module, codma_rd_watchdog (inputs: reload, enable; output: expired), instantiated only under CODMA_RD_TIMEOUT_EN.

Test Plan:
- 32B read: need_read_i=1, reg_addr=0x1000, reg_size=9; grant after 3 cycles; 8 rvalid beats of 0xA0..0xA7 -> bus_addr_o=0x1000, data_reg[0..7]=0xA0..0xA7, rd_state_next_s=RD_IDLE on the 8th beat, need_read_o=0 from the accept cycle.
- 8B read with gaps: reg_size=3, beats 0x11/0x22 separated by 4 idle cycles -> data_reg[0]=0x11, data_reg[1]=0x22, data_reg[2..7]=0.
- Bus error on the 3rd beat of a 16B read -> rd_error_o pulse, state RD_IDLE, data_reg[0..1] retained, no further capture.
- Invalid size code reg_size=5 -> no bus_req_o, rd_error_o one-cycle pulse, state stays RD_IDLE.
- Reset asserted during RD_GRANTED after 2 beats -> immediate RD_IDLE, data_reg=0, bus_req_o=0; new request afterwards completes normally.
- With CODMA_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16: grant withheld -> rd_error_o on the 16th cycle in RD_REQUEST; without the macro the same stimulus remains in RD_REQUEST.

Source files
------------

// File: rtl/read_pkg.sv
// Shared types and constants for the CoDMA bus-read engine.
package read_pkg;

    localparam int unsigned RD_SIZE_W  = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MAX_BEATS  = 8;
    localparam int unsigned BEAT_CNT_W = 4;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_REQUEST = 2'd1,
        RD_GRANTED = 2'd2
    } read_state_t;

    localparam logic [RD_SIZE_W-1:0] RD_SIZE_8B  = 8'd3;
    localparam logic [RD_SIZE_W-1:0] RD_SIZE_16B = 8'd8;
    localparam logic [RD_SIZE_W-1:0] RD_SIZE_32B = 8'd9;

    // Beat count for a size code; zero marks an unsupported code.
    function automatic logic [BEAT_CNT_W-1:0] size_to_beats(input logic [RD_SIZE_W-1:0] code);
        logic [BEAT_CNT_W-1:0] beats;
        case (code)
            RD_SIZE_8B:  beats = 4'd2;
            RD_SIZE_16B: beats = 4'd4;
            RD_SIZE_32B: beats = 4'd8;
            default:     beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/codma_read_machine_watchdog.sv
// Stall watchdog for the read engine: counts enabled cycles since the last
// reload and flags expiry on the TIMEOUT_CYCLES-th one.
module codma_rd_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Expiry is combinational so the owner can leave its state in the same cycle.
    assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycle counter, cleared on reload and frozen once expired.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/codma_read_machine.sv
// CoDMA bus-read engine: takes one read request from the control FSM, issues a
// single burst on the system bus and assembles the returned beats into data_reg.
// Optional stall watchdog: define CODMA_RD_TIMEOUT_EN.
module codma_read_machine
    import read_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                need_read_i,
    output logic                                need_read_o,
    input  logic [ADDR_W-1:0]                   reg_addr,
    input  logic [RD_SIZE_W-1:0]                reg_size,
    output read_state_t                         rd_state_r,
    output read_state_t                         rd_state_next_s,
    output logic [MAX_BEATS-1:0][DATA_W-1:0]    data_reg,
    output logic                                rd_error_o,
    output logic                                bus_req_o,
    input  logic                                bus_gnt_i,
    output logic [ADDR_W-1:0]                   bus_addr_o,
    output logic [RD_SIZE_W-1:0]                bus_size_o,
    input  logic                                bus_rvalid_i,
    input  logic [DATA_W-1:0]                   bus_rdata_i,
    input  logic                                bus_error_i
);

    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [BEAT_CNT_W-1:0] beats_total;

    logic latch_c;
    logic grant_c;
    logic beat_c;
    logic err_c;
    logic timeout_c;

`ifdef CODMA_RD_TIMEOUT_EN
    logic wd_reload_c;
    logic wd_enable_c;

    // Watchdog runs while a burst is outstanding and restarts on every state change or beat.
    assign wd_enable_c = (rd_state_r != RD_IDLE);
    assign wd_reload_c = (rd_state_next_s != rd_state_r) || beat_c;

    codma_rd_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .reload    (wd_reload_c),
        .enable    (wd_enable_c),
        .expired   (timeout_c)
    );
`else
    // Without the watchdog the engine waits indefinitely; the parameter is inert.
    assign timeout_c = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    // Next-state, request feedback and per-cycle action strobes.
    always_comb begin
        rd_state_next_s = rd_state_r;
        need_read_o     = 1'b0;
        latch_c         = 1'b0;
        grant_c         = 1'b0;
        beat_c          = 1'b0;
        err_c           = 1'b0;

        case (rd_state_r)
            RD_IDLE: begin
                need_read_o = need_read_i;
                if (need_read_i) begin
                    // Request is consumed either way; the control FSM drops it next cycle.
                    latch_c     = 1'b1;
                    need_read_o = 1'b0;
                    if (size_to_beats(reg_size) != '0) begin
                        rd_state_next_s = RD_REQUEST;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end

            RD_REQUEST: begin
                if (bus_error_i) begin
                    err_c           = 1'b1;
                    rd_state_next_s = RD_IDLE;
                end else if (bus_gnt_i) begin
                    grant_c         = 1'b1;
                    rd_state_next_s = RD_GRANTED;
                end else if (timeout_c) begin
                    err_c           = 1'b1;
                    rd_state_next_s = RD_IDLE;
                end
            end

            RD_GRANTED: begin
                if (bus_rvalid_i && (beat_cnt < beats_total)) begin
                    beat_c = 1'b1;
                    if (beat_cnt == beats_total - 4'd1) begin
                        rd_state_next_s = RD_IDLE;
                    end
                end
                // An error overrides completion, but a coincident beat is still captured.
                if (bus_error_i || (timeout_c && !beat_c)) begin
                    err_c           = 1'b1;
                    rd_state_next_s = RD_IDLE;
                end
            end

            default: begin
                rd_state_next_s = RD_IDLE;
            end
        endcase
    end

    // State register and registered bus-side outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_state_r <= RD_IDLE;
            bus_req_o  <= 1'b0;
            rd_error_o <= 1'b0;
        end else begin
            rd_state_r <= rd_state_next_s;
            bus_req_o  <= (rd_state_next_s == RD_REQUEST);
            rd_error_o <= err_c;
        end
    end

    // Request parameters captured when the control FSM asks for a read.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus_addr_o  <= '0;
            bus_size_o  <= '0;
            beats_total <= '0;
        end else if (latch_c) begin
            bus_addr_o  <= reg_addr;
            bus_size_o  <= reg_size;
            beats_total <= size_to_beats(reg_size);
        end
    end

    // Beat assembly: cleared on grant so unfilled words read as zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_cnt <= '0;
            data_reg <= '0;
        end else if (grant_c) begin
            beat_cnt <= '0;
            data_reg <= '0;
        end else if (beat_c) begin
            data_reg[beat_cnt[2:0]] <= bus_rdata_i;
            beat_cnt                <= beat_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_codma_read_machine.sv
// Directed and randomized bench for codma_read_machine with a word-array reference model.
module tb_codma_read_machine;
    import read_pkg::*;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              need_read_i;
    logic              need_read_o;
    logic [31:0]       reg_addr;
    logic [7:0]        reg_size;
    read_state_t       rd_state_r;
    read_state_t       rd_state_next_s;
    logic [7:0][31:0]  data_reg;
    logic              rd_error_o;
    logic              bus_req_o;
    logic              bus_gnt_i;
    logic [31:0]       bus_addr_o;
    logic [7:0]        bus_size_o;
    logic              bus_rvalid_i;
    logic [31:0]       bus_rdata_i;
    logic              bus_error_i;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_data [8];

    codma_read_machine #(
        .TIMEOUT_CYCLES (16),
        .ADDR_W         (32)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .need_read_i     (need_read_i),
        .need_read_o     (need_read_o),
        .reg_addr        (reg_addr),
        .reg_size        (reg_size),
        .rd_state_r      (rd_state_r),
        .rd_state_next_s (rd_state_next_s),
        .data_reg        (data_reg),
        .rd_error_o      (rd_error_o),
        .bus_req_o       (bus_req_o),
        .bus_gnt_i       (bus_gnt_i),
        .bus_addr_o      (bus_addr_o),
        .bus_size_o      (bus_size_o),
        .bus_rvalid_i    (bus_rvalid_i),
        .bus_rdata_i     (bus_rdata_i),
        .bus_error_i     (bus_error_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) exp_data[i] = 32'd0;
    endtask

    task automatic chk_data();
        for (int i = 0; i < 8; i++) chk($sformatf("data_reg[%0d]", i), data_reg[i], exp_data[i]);
    endtask

    function automatic int beats_of(input logic [7:0] size);
        return (size == 8'd3) ? 2 : (size == 8'd8) ? 4 : 8;
    endfunction

    // One complete request/grant/beat sequence, with optional error or reset injection.
    task automatic do_burst(input logic [31:0] addr, input logic [7:0] size, input int gnt_dly,
                            input int gap_min, input int gap_max, input int err_beat,
                            input bit err_last, input int rst_beat, input bit rand_data,
                            input logic [31:0] base, input logic [31:0] stride);
        int n;
        int gap;
        bit err_seen;
        logic [31:0] v;
        n = beats_of(size);
        err_seen = 1'b0;

        need_read_i = 1'b1; reg_addr = addr; reg_size = size;
        #1;
        chk("accept_need_read_o", 32'(need_read_o), 32'd0);
        chk("accept_next_state", 32'(rd_state_next_s), 32'(RD_REQUEST));
        cyc();
        need_read_i = 1'b0;
        chk("req_state", 32'(rd_state_r), 32'(RD_REQUEST));
        chk("req_bus_req", 32'(bus_req_o), 32'd1);
        chk("req_bus_addr", bus_addr_o, addr);
        chk("req_bus_size", 32'(bus_size_o), 32'(size));

        for (int i = 0; i < gnt_dly; i++) begin
            bus_rvalid_i = 1'($urandom_range(1, 0));
            bus_rdata_i  = $urandom;
            need_read_i  = 1'($urandom_range(1, 0));
            reg_size     = 8'($urandom);
            #1;
            chk("wait_need_read_o", 32'(need_read_o), 32'd0);
            cyc();
            chk("wait_state", 32'(rd_state_r), 32'(RD_REQUEST));
            chk("wait_bus_req", 32'(bus_req_o), 32'd1);
            chk("wait_no_error", 32'(rd_error_o), 32'd0);
        end
        bus_rvalid_i = 1'b0; need_read_i = 1'b0;
        bus_gnt_i = 1'b1;
        cyc();
        bus_gnt_i = 1'b0;
        clear_model();
        chk("gnt_state", 32'(rd_state_r), 32'(RD_GRANTED));
        chk("gnt_bus_req", 32'(bus_req_o), 32'd0);

        for (int k = 0; k < n; k++) begin
            gap = int'($urandom_range(gap_max, gap_min));
            for (int g = 0; g < gap; g++) begin
                need_read_i = 1'($urandom_range(1, 0));
                cyc();
                chk("gap_state", 32'(rd_state_r), 32'(RD_GRANTED));
            end
            if (k == rst_beat) begin
                reset_n_i = 1'b0; bus_rvalid_i = 1'b0; need_read_i = 1'b0;
                #1;
                clear_model();
                chk("rst_state", 32'(rd_state_r), 32'(RD_IDLE));
                chk("rst_bus_req", 32'(bus_req_o), 32'd0);
                chk("rst_bus_addr", bus_addr_o, 32'd0);
                chk("rst_error", 32'(rd_error_o), 32'd0);
                chk_data();
                @(posedge clk_i);
                #3;
                reset_n_i = 1'b1;
                cyc();
                chk("post_rst_bus_req", 32'(bus_req_o), 32'd0);
                chk("post_rst_state", 32'(rd_state_r), 32'(RD_IDLE));
                return;
            end
            if (k == err_beat) begin
                bus_error_i = 1'b1; bus_rvalid_i = 1'b0;
                #1;
                chk("err_next_state", 32'(rd_state_next_s), 32'(RD_IDLE));
                cyc();
                bus_error_i = 1'b0; need_read_i = 1'b0;
                chk("err_state", 32'(rd_state_r), 32'(RD_IDLE));
                chk("err_pulse", 32'(rd_error_o), 32'd1);
                chk("err_bus_req", 32'(bus_req_o), 32'd0);
                err_seen = 1'b1;
                break;
            end
            v = rand_data ? $urandom : base + stride * 32'(k);
            bus_rvalid_i = 1'b1; bus_rdata_i = v; exp_data[k] = v;
            need_read_i = 1'($urandom_range(1, 0));
            if (k == n - 1 && err_last) bus_error_i = 1'b1;
            #1;
            chk("beat_next_state", 32'(rd_state_next_s), (k == n - 1) ? 32'(RD_IDLE) : 32'(RD_GRANTED));
            chk("beat_need_read_o", 32'(need_read_o), 32'd0);
            cyc();
            bus_rvalid_i = 1'b0; bus_error_i = 1'b0; need_read_i = 1'b0;
        end

        if (!err_seen) begin
            chk("end_state", 32'(rd_state_r), 32'(RD_IDLE));
            chk("end_error", 32'(rd_error_o), 32'(err_last));
            chk("end_bus_req", 32'(bus_req_o), 32'd0);
        end
        // A stray beat in idle must not disturb the assembled data.
        bus_rvalid_i = 1'b1; bus_rdata_i = $urandom;
        cyc();
        bus_rvalid_i = 1'b0;
        chk("idle_error_cleared", 32'(rd_error_o), 32'd0);
        chk("idle_state", 32'(rd_state_r), 32'(RD_IDLE));
        chk("hold_bus_addr", bus_addr_o, addr);
        chk("hold_bus_size", 32'(bus_size_o), 32'(size));
        chk_data();
    endtask

    initial begin
        logic [7:0] sizes [3];
        sizes[0] = 8'd3; sizes[1] = 8'd8; sizes[2] = 8'd9;

        reset_n_i = 1'b0; need_read_i = 1'b0; reg_addr = 32'd0; reg_size = 8'd0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0; bus_error_i = 1'b0;
        clear_model();
        #12;
        chk("reset_state", 32'(rd_state_r), 32'(RD_IDLE));
        chk("reset_bus_req", 32'(bus_req_o), 32'd0);
        chk("reset_bus_addr", bus_addr_o, 32'd0);
        chk("reset_bus_size", 32'(bus_size_o), 32'd0);
        chk("reset_error", 32'(rd_error_o), 32'd0);
        chk("reset_need_read_o", 32'(need_read_o), 32'd0);
        chk_data();
        reset_n_i = 1'b1;
        cyc();

        // 32B read, grant after three cycles, beats 0xA0..0xA7 back to back.
        do_burst(32'h1000, 8'd9, 3, 0, 0, -1, 1'b0, -1, 1'b0, 32'hA0, 32'h1);
        // 8B read with four idle cycles before each beat: 0x11, 0x22.
        do_burst(32'h2000, 8'd3, 1, 4, 4, -1, 1'b0, -1, 1'b0, 32'h11, 32'h11);

        // Invalid size code: error pulse, no bus request.
        need_read_i = 1'b1; reg_addr = 32'h2400; reg_size = 8'd5;
        #1;
        chk("bad_size_need_read_o", 32'(need_read_o), 32'd0);
        chk("bad_size_next_state", 32'(rd_state_next_s), 32'(RD_IDLE));
        cyc();
        need_read_i = 1'b0;
        chk("bad_size_pulse", 32'(rd_error_o), 32'd1);
        chk("bad_size_bus_req", 32'(bus_req_o), 32'd0);
        chk("bad_size_state", 32'(rd_state_r), 32'(RD_IDLE));
        cyc();
        chk("bad_size_pulse_end", 32'(rd_error_o), 32'd0);
        chk("bad_size_bus_req2", 32'(bus_req_o), 32'd0);

        // 16B read with bus error in place of the third beat.
        do_burst(32'h3000, 8'd8, 0, 0, 1, 2, 1'b0, -1, 1'b1, 32'h0, 32'h0);
        // 8B read with error coincident with the final beat.
        do_burst(32'h3100, 8'd3, 2, 0, 2, -1, 1'b1, -1, 1'b1, 32'h0, 32'h0);
        // Reset after two beats of a 32B read, then a clean read.
        do_burst(32'h4000, 8'd9, 2, 0, 1, -1, 1'b0, 2, 1'b1, 32'h0, 32'h0);
        do_burst(32'h4040, 8'd9, 1, 0, 1, -1, 1'b0, -1, 1'b1, 32'h0, 32'h0);
        // Long grant stall: the default build keeps waiting without error.
        do_burst(32'h5000, 8'd8, 20, 0, 0, -1, 1'b0, -1, 1'b1, 32'h0, 32'h0);

        for (int r = 0; r < 8; r++) begin
            do_burst($urandom & 32'hFFFF_FFFC, sizes[$urandom_range(2, 0)],
                     int'($urandom_range(5, 0)), 0, 3, -1, 1'b0, -1, 1'b1, 32'h0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
